telemetry_framer: RTL and testbench

Upstream feeder of the downlink serial_tx. Periodically (or on demand) snapshots the packed sensor register bus (pressure, temperatures, gyro/accel/magnetometer words) and emits one framed packet byte-by-byte over the serial_tx new_data/busy/block handshake. Each frame carries sync bytes, length, sequence number, big-endian payload and a checksum, so the ground side can resynchronise on byte loss.

---
 rtl/telemetry_framer_pkg.sv | 26 ++
 rtl/frame_check_accum.sv | 37 +++
 rtl/telemetry_framer.sv | 135 +++++++++++++
 tb/tb_telemetry_framer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_framer_pkg.sv
// Shared constants, FSM state type and CRC-8 step function for telemetry_framer.
package telemetry_framer_pkg;

    localparam logic [7:0] FRAME_SYNC0 = 8'hA5;
    localparam logic [7:0] FRAME_SYNC1 = 8'h5A;
    localparam logic [7:0] CRC8_POLY   = 8'h07;
    localparam int         HDR_LEN     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    // One full byte of MSB-first CRC-8, unrolled into 8 combinational steps.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_check_accum.sv
// Frame check accumulator: additive two's-complement checksum, or CRC-8 when
// TELEMETRY_FRAMER_CRC8_EN is defined.
module frame_check_accum
    import telemetry_framer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic [7:0] check_out
);

    logic [7:0] acc;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (byte_valid) begin
`ifdef TELEMETRY_FRAMER_CRC8_EN
            acc <= crc8_update(acc, byte_in);
`else
            acc <= acc + byte_in;
`endif
        end
    end

`ifdef TELEMETRY_FRAMER_CRC8_EN
    assign check_out = acc;
`else
    assign check_out = 8'h00 - acc;
`endif

endmodule

// File: rtl/telemetry_framer.sv
// Snapshots sensor_bus and streams one framed packet to serial_tx per trigger.
// Define TELEMETRY_FRAMER_CRC8_EN to replace the additive checksum with CRC-8.
module telemetry_framer
    import telemetry_framer_pkg::*;
#(
    parameter int NUM_WORDS     = 13,
    parameter int PERIOD_CYCLES = 5000000,
    parameter int CTR_SIZE      = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WORDS*16-1:0] sensor_bus,
    input  logic                    start,
    input  logic                    enable,
    output logic [7:0]              tx_data,
    output logic                    new_tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_block,
    output logic                    frame_active,
    output logic [7:0]              seq,
    output logic                    overrun
);

    localparam int TOTAL_BYTES = NUM_WORDS*2 + HDR_LEN + 1;
    localparam int IDX_W       = $clog2(TOTAL_BYTES);
    localparam logic [IDX_W-1:0] SYNC1_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LEN_IDX   = IDX_W'(2);
    localparam logic [IDX_W-1:0] SEQ_IDX   = IDX_W'(3);
    localparam logic [IDX_W-1:0] CHK_IDX   = IDX_W'(TOTAL_BYTES-1);
    localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(TOTAL_BYTES);
    localparam logic [7:0]       LEN_BYTE  = 8'(NUM_WORDS*2);
    localparam logic [CTR_SIZE-1:0] PERIOD_LAST =
        (PERIOD_CYCLES > 0) ? CTR_SIZE'(PERIOD_CYCLES-1) : '0;

    state_t                  state;
    logic [IDX_W-1:0]        byte_idx;
    logic [NUM_WORDS*16-1:0] snapshot;
    logic [CTR_SIZE-1:0]     period_ctr;
    logic                    period_hit, trigger, accept, tx_ready, strobe, acc_valid;
    logic [7:0]              cur_byte, payload_byte, check_byte;

    assign period_hit = (PERIOD_CYCLES != 0) && (period_ctr == PERIOD_LAST);
    assign trigger    = start | period_hit;
    assign accept     = (state == ST_IDLE) && trigger && enable;
    assign tx_ready   = !tx_busy && !tx_block;
    assign strobe     = (state == ST_SEND) && tx_ready;
    assign acc_valid  = strobe && (byte_idx >= LEN_IDX) && (byte_idx < CHK_IDX);

    // Free-running period counter, independent of enable and frame state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_ctr <= '0;
        end else if (period_hit) begin
            period_ctr <= '0;
        end else if (PERIOD_CYCLES != 0) begin
            period_ctr <= period_ctr + CTR_SIZE'(1);
        end
    end

    // NOTE: snapshot is pure datapath written before use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            snapshot <= sensor_bus;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        payload_byte = 8'h00;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (int'(byte_idx) == HDR_LEN + 2*w)     payload_byte = snapshot[w*16+8 +: 8];
            if (int'(byte_idx) == HDR_LEN + 2*w + 1) payload_byte = snapshot[w*16 +: 8];
        end
        if (byte_idx == '0)             cur_byte = FRAME_SYNC0;
        else if (byte_idx == SYNC1_IDX) cur_byte = FRAME_SYNC1;
        else if (byte_idx == LEN_IDX)   cur_byte = LEN_BYTE;
        else if (byte_idx == SEQ_IDX)   cur_byte = seq;
        else if (byte_idx == CHK_IDX)   cur_byte = check_byte;
        else                            cur_byte = payload_byte;
    end

    frame_check_accum u_check (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .byte_valid (acc_valid),
        .byte_in    (cur_byte),
        .check_out  (check_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            byte_idx     <= '0;
            tx_data      <= 8'h00;
            new_tx_data  <= 1'b0;
            frame_active <= 1'b0;
            seq          <= 8'h00;
            overrun      <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            if (trigger && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        byte_idx     <= '0;
                        frame_active <= 1'b1;
                        state        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_data     <= cur_byte;
                        new_tx_data <= 1'b1;
                        byte_idx    <= byte_idx + IDX_W'(1);
                        state       <= ST_GAP;
                    end
                end
                // serial_tx raises busy one cycle late, so GAP never looks at it.
                ST_GAP: begin
                    state <= (byte_idx == END_IDX) ? ST_DONE : ST_SEND;
                end
                ST_DONE: begin
                    frame_active <= 1'b0;
                    seq          <= seq + 8'd1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: one manual-trigger DUT and one auto-trigger DUT.
module tb_telemetry_framer;

    localparam int NW        = 2;
    localparam int FRAME_LEN = NW*2 + 5;
    localparam int B2B_N     = 257;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, enable, tx_busy, tx_block;
    logic [NW*16-1:0] sensor_bus;
    logic [7:0]       tx_data, seq;
    logic             new_tx_data, frame_active, overrun;

    logic             rst_n_b, start_b, enable_b, tx_busy_b, tx_block_b;
    logic [NW*16-1:0] sensor_bus_b;
    logic [7:0]       tx_data_b, seq_b;
    logic             new_tx_data_b, frame_active_b, overrun_b;

    telemetry_framer #(.NUM_WORDS(NW), .PERIOD_CYCLES(0), .CTR_SIZE(1)) dut (
        .clk(clk), .rst_n(rst_n), .sensor_bus(sensor_bus), .start(start), .enable(enable),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy), .tx_block(tx_block),
        .frame_active(frame_active), .seq(seq), .overrun(overrun)
    );

    telemetry_framer #(.NUM_WORDS(NW), .PERIOD_CYCLES(200), .CTR_SIZE(8)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .sensor_bus(sensor_bus_b), .start(start_b), .enable(enable_b),
        .tx_data(tx_data_b), .new_tx_data(new_tx_data_b), .tx_busy(tx_busy_b), .tx_block(tx_block_b),
        .frame_active(frame_active_b), .seq(seq_b), .overrun(overrun_b)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] byte_q[$];
    logic [7:0] b_q[$];
    logic [7:0] exp_frame [FRAME_LEN];

    // Byte monitor: samples strobes 2 time units after the active edge.
    always begin
        @(posedge clk);
        #2;
        if (new_tx_data === 1'b1)   byte_q.push_back(tx_data);
        if (new_tx_data_b === 1'b1) b_q.push_back(tx_data_b);
    end

    // Reference frame: sync, LEN, SEQ, big-endian words, then checksum or CRC-8.
    task automatic build_frame(input logic [7:0] s, input logic [15:0] w0, input logic [15:0] w1);
        logic [7:0] sum, crc;
        exp_frame[0] = 8'hA5;       exp_frame[1] = 8'h5A;
        exp_frame[2] = 8'(NW*2);    exp_frame[3] = s;
        exp_frame[4] = w0[15:8];    exp_frame[5] = w0[7:0];
        exp_frame[6] = w1[15:8];    exp_frame[7] = w1[7:0];
        sum = 8'h00;
        crc = 8'h00;
        for (int i = 2; i < FRAME_LEN-1; i++) begin
            sum = sum + exp_frame[i];
            crc = crc ^ exp_frame[i];
            for (int k = 0; k < 8; k++) crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
`ifdef TELEMETRY_FRAMER_CRC8_EN
        exp_frame[FRAME_LEN-1] = crc;
`else
        exp_frame[FRAME_LEN-1] = 8'h00 - sum;
`endif
    endtask

    task automatic wait_bytes(input int n, input int budget, input bit use_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if ((use_b ? b_q.size() : byte_q.size()) >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (frame_active === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (tx_data !== 8'h00)      begin miscompares++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        vectors++; if (new_tx_data !== 1'b0)   begin miscompares++; $display("FAIL reset_new_tx_data: got %b expected 0", new_tx_data); end
        vectors++; if (frame_active !== 1'b0)  begin miscompares++; $display("FAIL reset_frame_active: got %b expected 0", frame_active); end
        vectors++; if (seq !== 8'h00)          begin miscompares++; $display("FAIL reset_seq: got %h expected 00", seq); end
        vectors++; if (overrun !== 1'b0)       begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        vectors++; if (frame_active_b !== 1'b0) begin miscompares++; $display("FAIL reset_b_frame_active: got %b expected 0", frame_active_b); end
        @(posedge clk); #1 rst_n = 1'b1; rst_n_b = 1'b1;
    endtask

    task automatic test_basic_frame();
        bit ok;
        logic [7:0] got;
        byte_q.delete();
        sensor_bus = {16'hABCD, 16'h1234};
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        sensor_bus = 32'hFFFF_0000;
        @(negedge clk);
        vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL basic_active_t1: got %b expected 1", frame_active); end
        vectors++; if (new_tx_data !== 1'b0)  begin miscompares++; $display("FAIL basic_strobe_t1: got %b expected 0", new_tx_data); end
        @(negedge clk);
        vectors++; if (new_tx_data !== 1'b1 || tx_data !== 8'hA5) begin
            miscompares++; $display("FAIL basic_first_byte_t2: got strobe %b data %h expected 1 a5", new_tx_data, tx_data);
        end
        wait_bytes(FRAME_LEN, 200, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout: got %0d bytes expected %0d", byte_q.size(), FRAME_LEN); end
        wait_idle(50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_idle_timeout: got frame_active %b expected 0", frame_active); end
        build_frame(8'h00, 16'h1234, 16'hABCD);
        for (int i = 0; i < FRAME_LEN; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            vectors++;
            if (got !== exp_frame[i]) begin miscompares++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, got, exp_frame[i]); end
        end
`ifndef TELEMETRY_FRAMER_CRC8_EN
        vectors++; if (byte_q[FRAME_LEN-1] !== 8'h3E) begin miscompares++; $display("FAIL basic_chk_hand: got %h expected 3e", byte_q[FRAME_LEN-1]); end
`endif
        vectors++; if (seq !== 8'h01)     begin miscompares++; $display("FAIL basic_seq_after: got %h expected 01", seq); end
        vectors++; if (overrun !== 1'b0)  begin miscompares++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
        vectors++; if (byte_q.size() != FRAME_LEN) begin miscompares++; $display("FAIL basic_count: got %0d expected %0d", byte_q.size(), FRAME_LEN); end
    endtask

    task automatic test_enable_gate();
        byte_q.delete();
        enable = 1'b0;
        pulse_start();
        repeat (20) @(negedge clk);
        vectors++; if (byte_q.size() != 0)    begin miscompares++; $display("FAIL disabled_bytes: got %0d expected 0", byte_q.size()); end
        vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL disabled_active: got %b expected 0", frame_active); end
        vectors++; if (overrun !== 1'b0)      begin miscompares++; $display("FAIL disabled_overrun: got %b expected 0", overrun); end
        vectors++; if (seq !== 8'h01)         begin miscompares++; $display("FAIL disabled_seq: got %h expected 01", seq); end
        enable = 1'b1;
    endtask

    task automatic test_block_busy();
        bit ok;
        logic [7:0] got;
        byte_q.delete();
        sensor_bus = {16'h0304, 16'h0102};
        pulse_start();
        wait_bytes(2, 50, 1'b0, ok);
        tx_block = 1'b1;
        vectors++; if (!ok) begin miscompares++; $display("FAIL block_pre_timeout: got %0d bytes expected 2", byte_q.size()); end
        repeat (100) @(negedge clk);
        vectors++; if (byte_q.size() != 2)    begin miscompares++; $display("FAIL block_held_bytes: got %0d expected 2", byte_q.size()); end
        vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL block_held_active: got %b expected 1", frame_active); end
        tx_block = 1'b0;
        wait_bytes(5, 50, 1'b0, ok);
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        vectors++; if (byte_q.size() != 5) begin miscompares++; $display("FAIL busy_held_bytes: got %0d expected 5", byte_q.size()); end
        tx_busy = 1'b0;
        wait_bytes(FRAME_LEN, 100, 1'b0, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL block_timeout: got %0d bytes expected %0d", byte_q.size(), FRAME_LEN); end
        wait_idle(50, ok);
        repeat (10) @(negedge clk);
        vectors++; if (byte_q.size() != FRAME_LEN) begin miscompares++; $display("FAIL block_count: got %0d expected %0d", byte_q.size(), FRAME_LEN); end
        build_frame(8'h01, 16'h0102, 16'h0304);
        for (int i = 0; i < FRAME_LEN; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            vectors++;
            if (got !== exp_frame[i]) begin miscompares++; $display("FAIL block_byte[%0d]: got %h expected %h", i, got, exp_frame[i]); end
        end
        vectors++; if (seq !== 8'h02) begin miscompares++; $display("FAIL block_seq_after: got %h expected 02", seq); end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] got;
        byte_q.delete();
        sensor_bus = {16'hCAFE, 16'hBEEF};
        pulse_start();
        wait_bytes(5, 50, 1'b0, ok);
        pulse_start();
        sensor_bus = 32'h0000_0000;
        @(negedge clk);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        wait_bytes(FRAME_LEN, 100, 1'b0, ok);
        wait_idle(50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL overrun_idle_timeout: got frame_active %b expected 0", frame_active); end
        repeat (40) @(negedge clk);
        vectors++; if (byte_q.size() != FRAME_LEN) begin miscompares++; $display("FAIL overrun_count: got %0d expected %0d", byte_q.size(), FRAME_LEN); end
        vectors++; if (overrun !== 1'b1)      begin miscompares++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL overrun_no_second: got %b expected 0", frame_active); end
        vectors++; if (seq !== 8'h03)         begin miscompares++; $display("FAIL overrun_seq: got %h expected 03", seq); end
        build_frame(8'h02, 16'hBEEF, 16'hCAFE);
        for (int i = 0; i < FRAME_LEN; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            vectors++;
            if (got !== exp_frame[i]) begin miscompares++; $display("FAIL overrun_byte[%0d]: got %h expected %h", i, got, exp_frame[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n0;
        logic [7:0] got;
        byte_q.delete();
        sensor_bus = {16'h7788, 16'h5566};
        pulse_start();
        wait_bytes(6, 50, 1'b0, ok);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n0 = byte_q.size();
        vectors++; if (seq !== 8'h00)          begin miscompares++; $display("FAIL rstmid_seq: got %h expected 00", seq); end
        vectors++; if (frame_active !== 1'b0)  begin miscompares++; $display("FAIL rstmid_active: got %b expected 0", frame_active); end
        vectors++; if (overrun !== 1'b0)       begin miscompares++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
        vectors++; if (tx_data !== 8'h00)      begin miscompares++; $display("FAIL rstmid_tx_data: got %h expected 00", tx_data); end
        repeat (40) @(negedge clk);
        vectors++; if (byte_q.size() != n0) begin miscompares++; $display("FAIL rstmid_no_strobe: got %0d bytes expected %0d", byte_q.size(), n0); end
        byte_q.delete();
        pulse_start();
        wait_bytes(FRAME_LEN, 100, 1'b0, ok);
        wait_idle(50, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_refr_timeout: got frame_active %b expected 0", frame_active); end
        build_frame(8'h00, 16'h5566, 16'h7788);
        for (int i = 0; i < FRAME_LEN; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            vectors++;
            if (got !== exp_frame[i]) begin miscompares++; $display("FAIL rstmid_byte[%0d]: got %h expected %h", i, got, exp_frame[i]); end
        end
        vectors++; if (seq !== 8'h01) begin miscompares++; $display("FAIL rstmid_seq_after: got %h expected 01", seq); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] got;
        b_q.delete();
        @(posedge clk); #1 enable_b = 1'b1;
        wait_bytes(B2B_N*FRAME_LEN, B2B_N*200 + 600, 1'b1, ok);
        enable_b = 1'b0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got %0d bytes expected %0d", b_q.size(), B2B_N*FRAME_LEN); end
        for (int f = 0; f < B2B_N; f++) begin
            build_frame(8'(f), sensor_bus_b[15:0], sensor_bus_b[31:16]);
            for (int i = 0; i < FRAME_LEN; i++) begin
                got = (f*FRAME_LEN + i < b_q.size()) ? b_q[f*FRAME_LEN + i] : 8'hxx;
                vectors++;
                if (got !== exp_frame[i]) begin
                    miscompares++; $display("FAIL b2b_frame%0d_byte[%0d]: got %h expected %h", f, i, got, exp_frame[i]);
                end
            end
        end
        vectors++; if (overrun_b !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %b expected 0", overrun_b); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; enable = 1'b1; tx_busy = 1'b0; tx_block = 1'b0;
        sensor_bus = '0;
        rst_n_b = 1'b0; start_b = 1'b0; enable_b = 1'b0; tx_busy_b = 1'b0; tx_block_b = 1'b0;
        sensor_bus_b = {16'h9C3E, 16'h0F1E};

        test_reset();
        test_basic_frame();
        test_enable_gate();
        test_block_busy();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
